// File: rtl/fpmul_arbiter_pkg.sv
// ============================================================================
//  Module      : fpmul_arbiter_pkg
//  Description : Shared floating-point constants and helpers for the fpmul
//                arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpmul_arbiter_pkg;

    localparam int FP_W    = 32;
    localparam int FP_EXPW = 8;
    localparam int FP_MANW = 23;

    localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic               sign;
        logic [FP_EXPW-1:0] exp;
        logic [FP_MANW-1:0] man;
    } fp32_t;

    // Requester index reached by stepping 'offs' places from 'base', modulo n.
    function automatic int unsigned rr_slot(input int unsigned base,
                                            input int unsigned offs,
                                            input int unsigned n);
        int unsigned s;
        s = base + offs;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpmul_arbiter_if.sv
// ============================================================================
//  Module      : fpmul_arbiter_if
//  Description : Requester, multiplier and response bundle of fpmul_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpmul_arbiter_if import fpmul_arbiter_pkg::*; #(
    parameter int NREQ = 4
) ();

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [FP_W-1:0]      mul_a;
    logic [FP_W-1:0]      mul_b;
    logic [FP_W-1:0]      mul_c;
    logic                 mul_omu;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [FP_W-1:0]      rsp_c;
    logic                 rsp_omu;
    logic                 busy;

    // Environment side: requesters, the fpmul instance and the consumer.
    modport master (
        output req_valid, req_a, req_b, mul_c, mul_omu, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, rsp_omu, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_c, mul_omu, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, rsp_omu, busy
    );

endinterface

`default_nettype wire

// File: rtl/fpmul_resp_fifo.sv
// ============================================================================
//  Module      : fpmul_resp_fifo
//  Description : Show-ahead response FIFO; head fields hold the last popped
//                entry while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmul_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       wr_en,
    input  wire logic [W-1:0]               wr_data,
    input  wire logic                       rd_en,
    output logic      [W-1:0]               rd_data,
    output logic                            rd_valid,
    output logic      [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_last;

    logic          w_empty;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_pop   = rd_en & ~w_empty;

    assign rd_valid = ~w_empty;
    assign rd_data  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            r_count <= r_count + CW'(wr_en) - CW'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpmul_arbiter.sv
// ============================================================================
//  Module      : fpmul_arbiter
//  Description : Round-robin sharing of one registered fpmul among NREQ
//                requesters, with ID tracking and a credited response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmul_arbiter import fpmul_arbiter_pkg::*; #(
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input wire logic        clk,
    input wire logic        rst_n,
    fpmul_arbiter_if.slave  bus
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int EW  = IDW + FP_W + 1;

    logic [IDW-1:0]  r_ptr;
    logic [FP_W-1:0] r_mul_a;
    logic [FP_W-1:0] r_mul_b;
    logic [LAT:0]    r_tag_v;
    logic [IDW-1:0]  r_tag_id [LAT+1];
    logic [CW-1:0]   r_inflight;

    logic [NREQ-1:0] w_grant;
    logic            w_any;
    logic [IDW-1:0]  w_gid;
    logic            w_credit;
    logic            w_accept;
    logic            w_capture;
    logic [CW-1:0]   w_fifo_count;
    logic [EW-1:0]   w_head;

    always_comb begin
        int unsigned slot;
        logic [IDW-1:0] slot_id;
        w_grant = '0;
        w_any   = 1'b0;
        w_gid   = '0;
        slot    = 0;
        slot_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot    = rr_slot(32'(r_ptr), 32'(k), 32'(NREQ));
            slot_id = IDW'(slot);
            if (!w_any && bus.req_valid[slot_id]) begin
                w_any = 1'b1;
                w_gid = slot_id;
            end
        end
        if (w_any) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    // Registered counts only, so a same-cycle pop never reaches req_ready.
    assign w_credit  = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CW+1)'(DEPTH);
    assign w_accept  = w_any & w_credit & rst_n;
    assign w_capture = r_tag_v[LAT];

    assign bus.req_ready = rst_n ? (w_grant & {NREQ{w_credit}}) : '0;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.busy      = (r_inflight != '0) || (w_fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_tag_v    <= '0;
            r_inflight <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_ptr   <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
                r_mul_a <= bus.req_a[w_gid*FP_W +: FP_W];
                r_mul_b <= bus.req_b[w_gid*FP_W +: FP_W];
            end
            // Stage k lines up with the operands that entered fpmul k cycles ago.
            r_tag_v[0]  <= w_accept;
            r_tag_id[0] <= w_gid;
            for (int s = 1; s <= LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_capture);
        end
    end

    fpmul_resp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_resp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_capture),
        .wr_data  ({r_tag_id[LAT], bus.mul_c, bus.mul_omu}),
        .rd_en    (bus.rsp_ready),
        .rd_data  (w_head),
        .rd_valid (bus.rsp_valid),
        .count    (w_fifo_count)
    );

    assign {bus.rsp_id, bus.rsp_c, bus.rsp_omu} = w_head;

endmodule

`default_nettype wire

// File: tb/tb_fpmul_arbiter.sv
// ============================================================================
//  Module      : tb_fpmul_arbiter
//  Description : Directed and random bench for fpmul_arbiter with a
//                behavioural fpmul and a transaction-level response model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpmul_arbiter;
    import fpmul_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fpmul_arbiter_if #(.NREQ(NREQ)) bus ();

    fpmul_arbiter #(
        .NREQ  (NREQ),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- behavioural single-precision multiply ----------------
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {over_mul_under, product}; overflow gives infinity, underflow zero.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        real         p;
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        logic        s;
        p = f2r(a) * f2r(b);
        d = $realtobits(p);
        s = d[63];
        if (d[62:0] == 63'd0) return {1'b0, s, 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b1, s, 31'd0};
        return {1'b0, s, 8'(e), m[22:0]};
    endfunction

    always @(posedge clk) {bus.mul_omu, bus.mul_c} <= fmul(bus.mul_a, bus.mul_b);

    // ---------------- reference model state ----------------
    typedef struct {
        int          id;
        logic [31:0] c;
        logic        omu;
        int          vis;
    } rsp_t;

    rsp_t        sb[$];
    int          mptr, cyc;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        pend_v [NREQ];
    logic [31:0] pend_a [NREQ];
    logic [31:0] pend_b [NREQ];
    logic        refill_on, refill_rnd, rnd_mode;
    logic [31:0] fix_a, fix_b;
    int          obs_id[$];
    logic [31:0] obs_c[$];
    logic        obs_omu[$];
    int          obs_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_valid[k]         = pend_v[k];
            bus.req_a[k*32 +: 32]    = pend_a[k];
            bus.req_b[k*32 +: 32]    = pend_b[k];
        end
    endtask

    task automatic clear_pend();
        for (int k = 0; k < NREQ; k++) begin
            pend_v[k] = 1'b0;
            pend_a[k] = 32'd0;
            pend_b[k] = 32'd0;
        end
        drive();
    endtask

    // Sample at the falling edge, compare with the model, then advance the model.
    task automatic cycle_check();
        int              gid;
        logic [NREQ-1:0] exp_rdy;
        logic [32:0]     prod;
        rsp_t            r;
        bit              ev;
        @(negedge clk);
        gid = -1;
        if (sb.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int s;
                s = (mptr + k) % NREQ;
                if (gid < 0 && pend_v[s]) gid = s;
            end
        end
        exp_rdy = (gid >= 0) ? NREQ'(1 << gid) : '0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        ev = (sb.size() > 0) && (sb[0].vis <= cyc);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        check("busy", 64'(bus.busy), 64'(sb.size() > 0));
        if (|bus.req_ready) obs_acc++;
        if (ev) begin
            check("rsp_id",  64'(bus.rsp_id),  64'(sb[0].id));
            check("rsp_c",   64'(bus.rsp_c),   64'(sb[0].c));
            check("rsp_omu", 64'(bus.rsp_omu), 64'(sb[0].omu));
            if (bus.rsp_ready) begin
                obs_id.push_back(int'(bus.rsp_id));
                obs_c.push_back(bus.rsp_c);
                obs_omu.push_back(bus.rsp_omu);
                void'(sb.pop_front());
            end
        end
        if (gid >= 0) begin
            prod  = fmul(pend_a[gid], pend_b[gid]);
            r.id  = gid;
            r.c   = prod[31:0];
            r.omu = prod[32];
            r.vis = cyc + 2 + LAT;
            sb.push_back(r);
            mptr  = (gid + 1) % NREQ;
            pend_v[gid] = 1'b0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NREQ; k++) begin
            if (!pend_v[k]) begin
                if (refill_on) begin
                    pend_v[k] = 1'b1;
                    pend_a[k] = refill_rnd ? rnd_fp() : fix_a;
                    pend_b[k] = refill_rnd ? rnd_fp() : fix_b;
                end else if (rnd_mode && ($urandom_range(0, 2) == 0)) begin
                    pend_v[k] = 1'b1;
                    pend_a[k] = rnd_fp();
                    pend_b[k] = rnd_fp();
                end
            end
        end
        if (rnd_mode) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    function automatic bit any_pend();
        bit a;
        a = 1'b0;
        for (int k = 0; k < NREQ; k++) a = a | pend_v[k];
        return a;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        refill_on = 1'b0;
        rnd_mode  = 1'b0;
        bus.rsp_ready = 1'b1;
        while ((sb.size() > 0 || any_pend()) && n < 60) begin
            cycle_check();
            advance();
            n++;
        end
        check("drain_timeout", 64'(n < 60), 64'd1);
        cycle_check();
        advance();
    endtask

    // Reset lands mid-cycle so that outputs must clear without a clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_rsp_c",     64'(bus.rsp_c),     64'd0);
        check("rst_rsp_omu",   64'(bus.rsp_omu),   64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_mul_a",     64'(bus.mul_a),     64'd0);
        check("rst_mul_b",     64'(bus.mul_b),     64'd0);
        clear_pend();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        obs_id.delete();
        obs_c.delete();
        obs_omu.delete();
        mptr = 0; cyc = 0; obs_acc = 0;
        refill_on = 1'b0; refill_rnd = 1'b0; rnd_mode = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa [8];
        logic [31:0] pb [8];
        logic [31:0] c1 [$];
        logic        f1 [$];

        refill_on = 1'b0; refill_rnd = 1'b0; rnd_mode = 1'b0;
        fix_a = 32'd0; fix_b = 32'd0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            pend_v[k] = 1'b1;
            pend_a[k] = 32'h3F80_0000;
            pend_b[k] = 32'h3F80_0000;
        end
        drive();

        // Reset state with all requesters asserting valid.
        do_reset();

        // Single request from requester 2.
        pend_v[2] = 1'b1; pend_a[2] = 32'h3F80_0000; pend_b[2] = 32'h4000_0000;
        drive();
        cycle_check();
        check("single_grant", 64'(bus.req_ready), 64'b0100);
        advance(); cycle_check();
        advance(); cycle_check();
        advance(); cycle_check();
        check("single_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_id",    64'(bus.rsp_id),    64'd2);
        check("single_c",     64'(bus.rsp_c),     64'h4000_0000);
        check("single_omu",   64'(bus.rsp_omu),   64'd0);
        advance();
        drain();

        // Fairness: all four hold valid for eight cycles.
        do_reset();
        fix_a = 32'h4040_0000; fix_b = 32'h4080_0000;
        for (int k = 0; k < NREQ; k++) begin
            pend_v[k] = 1'b1; pend_a[k] = fix_a; pend_b[k] = fix_b;
        end
        refill_on = 1'b1;
        drive();
        for (int k = 0; k < 8; k++) begin
            cycle_check();
            check("fair_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
            if (k == 7) refill_on = 1'b0;
            advance();
        end
        clear_pend();
        drain();
        check("fair_count", 64'(obs_id.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check("fair_id", 64'(obs_id[k]), 64'(k % 4));
            check("fair_c",  64'(obs_c[k]),  64'h4140_0000);
        end

        // Back-pressure: consumer stalled, then released.
        do_reset();
        bus.rsp_ready = 1'b0;
        refill_on = 1'b1; refill_rnd = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            pend_v[k] = 1'b1; pend_a[k] = rnd_fp(); pend_b[k] = rnd_fp();
        end
        drive();
        for (int k = 0; k < 8; k++) begin
            cycle_check();
            advance();
        end
        check("bp_accepts", 64'(obs_acc), 64'(DEPTH));
        bus.rsp_ready = 1'b1;
        cycle_check();
        check("bp_pop_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_no_accept", 64'(bus.req_ready), 64'd0);
        advance();
        cycle_check();
        check("bp_resume", 64'(|bus.req_ready), 64'd1);
        refill_on = 1'b0;
        advance();
        drain();

        // Overflow flag through requester 1.
        do_reset();
        pend_v[1] = 1'b1; pend_a[1] = 32'h7F00_0000; pend_b[1] = 32'h7F00_0000;
        drive();
        drain();
        check("ovf_count", 64'(obs_id.size()), 64'd1);
        check("ovf_id",    64'(obs_id[0]),     64'd1);
        check("ovf_c",     64'(obs_c[0]),      64'(FP_POS_INF));
        check("ovf_omu",   64'(obs_omu[0]),    64'd1);

        // Reset with three results in flight or buffered.
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pend_v[k] = 1'b1; pend_a[k] = 32'h4040_0000; pend_b[k] = 32'h4000_0000;
        end
        drive();
        for (int k = 0; k < 3; k++) begin
            cycle_check();
            advance();
        end
        pend_v[3] = 1'b1; pend_a[3] = 32'h3F80_0000; pend_b[3] = 32'h3F80_0000;
        drive();
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle_check();
            advance();
        end
        for (int k = 0; k < NREQ; k++) begin
            pend_v[k] = 1'b1; pend_a[k] = 32'h3F80_0000; pend_b[k] = 32'h4000_0000;
        end
        drive();
        cycle_check();
        check("rst_first_grant", 64'(bus.req_ready), 64'b0001);
        advance();
        drain();
        check("rst_no_stale", 64'(obs_id.size()), 64'd4);

        // Swap symmetry: requester 1 with (a,b), requester 3 with (b,a).
        do_reset();
        pa[0] = 32'h3F80_0000; pb[0] = 32'h4000_0000;
        pa[1] = 32'h4040_0000; pb[1] = 32'h4080_0000;
        pa[2] = 32'h7F00_0000; pb[2] = 32'h7F00_0000;
        pa[3] = 32'h0080_0000; pb[3] = 32'h0080_0000;
        pa[4] = 32'hC0A0_0000; pb[4] = 32'h3E80_0000;
        pa[5] = 32'h3FC0_0000; pb[5] = 32'hBF40_0000;
        pa[6] = 32'h4B00_0001; pb[6] = 32'h3F80_0001;
        pa[7] = 32'h7F7F_FFFF; pb[7] = 32'h3F00_0000;
        for (int k = 0; k < 8; k++) begin
            pend_v[1] = 1'b1; pend_a[1] = pa[k]; pend_b[1] = pb[k];
            drive();
            cycle_check();
            advance();
        end
        drain();
        c1 = obs_c; f1 = obs_omu;
        for (int k = 0; k < 8; k++) check("swap_id1", 64'(obs_id[k]), 64'd1);
        obs_id.delete(); obs_c.delete(); obs_omu.delete();
        for (int k = 0; k < 8; k++) begin
            pend_v[3] = 1'b1; pend_a[3] = pb[k]; pend_b[3] = pa[k];
            drive();
            cycle_check();
            advance();
        end
        drain();
        check("swap_count", 64'(obs_c.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check("swap_id3", 64'(obs_id[k]),  64'd3);
            check("swap_c",   64'(obs_c[k]),   64'(c1[k]));
            check("swap_omu", 64'(obs_omu[k]), 64'(f1[k]));
        end

        // Random traffic with random consumer stalls.
        do_reset();
        rnd_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            cycle_check();
            advance();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

Shares one registered `fpmul` multiplier among `NREQ` requesters. The block sits between the requesters and the `fpmul` instance:
- it arbitrates round-robin among valid requests;
- it registers the winning operands into the multiplier;
- it tracks each request's requester ID through the multiplier latency;
- it returns results through a small response FIFO with valid/ready back-pressure.

At most one multiply is issued per cycle, so full multiplier throughput is sustained when the consumer keeps `rsp_ready` high.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `LAT`, 1: `fpmul` latency in clock edges, from operand change to `c` and `over_mul_under` valid.
- `DEPTH`, 4: response FIFO entries. Must be at least `LAT+2` for one result per cycle.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: request present, one bit per requester.
- `req_a` in `NREQ*32`: IEEE-754 single operand A. Requester `i` uses bits `[32i+31:32i]`.
- `req_b` in `NREQ*32`: operand B, same packing as `req_a`.
- `req_ready` out `NREQ`: request accepted this cycle. Bits are one-hot or zero.
- `mul_a` out 32: registered operand A to `fpmul.a`.
- `mul_b` out 32: registered operand B to `fpmul.b`.
- `mul_c` in 32: `fpmul.c` product.
- `mul_omu` in 1: `fpmul.over_mul_under` flag.
- `rsp_valid` out 1: FIFO head is valid.
- `rsp_ready` in 1: consumer takes the FIFO head.
- `rsp_id` out `$clog2(NREQ)`: requester index of the head entry.
- `rsp_c` out 32: product of the head entry.
- `rsp_omu` out 1: flag of the head entry.
- `busy` out 1: any request is in flight or any entry is in the FIFO.

## Operation

- **Handshake.** A transfer occurs when `req_valid[i] & req_ready[i]`. A requester holds `req_valid` and its operands stable until accepted. `rsp` uses the same valid/ready rule.
- **Arbitration.** Round-robin pointer `ptr`, reset value 0.
  - The grant goes to the first `i` with `req_valid[i]`, searching `ptr, ptr+1, …` modulo `NREQ`.
  - `req_ready[i] = grant[i] & credit`.
  - On acceptance of requester `i`, `ptr <= (i+1) mod NREQ`. Otherwise `ptr` holds.
- **Credit.** `credit = (inflight + fifo_count) < DEPTH`.
  - The check uses registered counts only.
  - A same-cycle pop does not free a credit until the next cycle, so there is no combinational path from `rsp_ready` to `req_ready`.
- **Issue.** On acceptance, `mul_a`/`mul_b` load the operands and a tag `{valid=1, id=i}` enters a `LAT+1`-stage shift register. The tag stages shift every cycle; a bubble shifts in as `valid=0`. `mul_a`/`mul_b` hold their last value when idle.
- **Capture.** When the last tag stage is valid, `{id, mul_c, mul_omu}` is written to the FIFO. Overflow cannot occur by construction of the credit check.
- **Counts.**
  - `inflight` increments on accept and decrements on capture.
  - `fifo_count` increments on capture and decrements on pop.
  - Simultaneous increment and decrement leaves the count unchanged.
- **Reset.** Reset clears `ptr`, all tag valids, both counts and the FIFO pointers, and zeroes `mul_a` and `mul_b`. Every output is 0 during reset: `req_ready` is forced 0 and `rsp_valid`, `rsp_id`, `rsp_c`, `rsp_omu` and `busy` are all 0.
- **Reset mid-operation.** Reset discards in-flight and buffered results; no response is produced for them.

## Timing

- Accept in cycle 0 → `mul_a`/`mul_b` valid in cycle 1 → `mul_c` valid in cycle `1+LAT` → FIFO write at the end of that cycle → `rsp_valid` in cycle `2+LAT`.
  - Latency is 3 cycles for `LAT=1` when the FIFO is empty.
- With `rsp_ready` held high, one accept and one response occur per cycle.
- Responses leave in acceptance order, not requester order.
- **FIFO full** (count `DEPTH`): `req_ready` is 0.
- **FIFO empty:** `rsp_valid` is 0, and head fields hold their last value (0 after reset).
- **Pointer wrap:** FIFO pointers wrap modulo `DEPTH`, and `ptr` wraps from `NREQ-1` to 0.
- **Simultaneous write and pop on a full FIFO:** both occur and the count stays at `DEPTH`.

## Structure

- Constants `FP_W=32`, IEEE field widths, and the canonical infinity and zero encodings belong in `fpmath_defs.v`, shared with `fpmul` and the benches.
- The response store is sub-module `fpmul_resp_fifo`: synchronous, show-ahead, parameterised by `DEPTH` and entry width `$clog2(NREQ)+33`, with async active-low reset.
- The arbiter, tag pipeline and counters stay in `fpmul_arbiter`. `fpmul` is instantiated by the parent, not inside this block.

## Test plan

- **Single request.** Requester 2 sends `a=3F800000`, `b=40000000`, `rsp_ready=1` → `req_ready=0100` in cycle 0; cycle 3 shows `rsp_valid=1`, `rsp_id=2`, `rsp_c=40000000`, `rsp_omu=0`.
- **Fairness.** All four requesters hold valid for 8 cycles with `40400000`×`40800000` → grant order is 0,1,2,3,0,1,2,3; eight responses of `41400000` with ids in the same order.
- **Back-pressure.** `rsp_ready=0` with continuous requests → exactly `DEPTH=4` accepts, then `req_ready=0`. Raising `rsp_ready` drains 4 results, and accepts resume one cycle after the first pop.
- **Overflow flag.** `7F000000`×`7F000000` → `rsp_omu=1`, `rsp_c` equal to `fpmul`'s infinity encoding `7F800000`, with the correct id.
- **Reset mid-operation.** Assert `rst_n=0` with 3 results in flight or buffered → all outputs 0 immediately. After release, no stale response appears, and the first new request is granted to requester 0.
- **Swap symmetry.** Replay the `a b c flag` pattern file through requester 1, then through requester 3 with `a`/`b` swapped → identical `rsp_c`/`rsp_omu` values with id 1 and id 3 respectively.
